// File: rtl/llander_pkg.sv
// Shared types and constants for the Lunar Lander thrust/turn/overlay
// input-conditioning block.
package llander_pkg;

  localparam int THRUST_W       = 8;
  localparam int OVL_W          = 32;
  localparam int DEF_MAX_THRUST = 254;

  typedef enum logic {
    ANALOG = 1'b0,
    DPAD   = 1'b1
  } thr_mode_t;

endpackage

// File: rtl/llander_thrust_ctrl_if.sv
// Control bundle between the joystick merge logic (master) and the thrust
// controller (slave).
//   dpad_mode, thr_up, thr_down, analog_y, analog_x, sel_n : master -> slave
//   thrust, turn_l, turn_r, ovl_en                         : slave -> master
interface llander_thrust_ctrl_if;
  import llander_pkg::*;

  logic                dpad_mode;
  logic                thr_up;
  logic                thr_down;
  logic [7:0]          analog_y;
  logic [7:0]          analog_x;
  logic                sel_n;
  logic [THRUST_W-1:0] thrust;
  logic                turn_l;
  logic                turn_r;
  logic                ovl_en;

  modport master (
    output dpad_mode, thr_up, thr_down, analog_y, analog_x, sel_n,
    input  thrust, turn_l, turn_r, ovl_en
  );

  modport slave (
    input  dpad_mode, thr_up, thr_down, analog_y, analog_x, sel_n,
    output thrust, turn_l, turn_r, ovl_en
  );

endinterface

// File: rtl/llander_tick_gen.sv
// D-pad step prescaler. Counts every clock and pulses tick for one clock when
// the count reaches TICK_DIV, giving a period of TICK_DIV+1 clocks.
//   clk_50 : clock
//   reset  : synchronous, active-high
//   clr    : synchronous clear, realigns the step phase
//   tick   : one-clock step strobe
module llander_tick_gen #(
  parameter int TICK_DIV = 196850
) (
  input  logic clk_50,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV));

  always_ff @(posedge clk_50) begin
    if (reset || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/llander_thrust_ctrl.sv
// Input conditioning for the Lunar Lander core: selects thrust from the
// analog stick or a D-pad ramp accumulator (bumpless handover), decodes
// analog turn requests with hysteresis and times the difficulty overlay.
//   clk_50 : clock
//   reset  : synchronous, active-high
//   bus    : control bundle (inputs from merge logic, thrust/turn/overlay out)
//
// state  | meaning
// ANALOG | thrust follows the clamped analog stick value
// DPAD   | thrust follows the D-pad accumulator, stepped on prescaler ticks
module llander_thrust_ctrl
  import llander_pkg::*;
#(
  parameter int          TICK_DIV   = 196850,
  parameter int          MAX_THRUST = DEF_MAX_THRUST,
  parameter int          TURN_ON    = 64,
  parameter int          TURN_OFF   = 48,
  parameter int unsigned OVL_CYCLES = 500000000
) (
  input  logic                 clk_50,
  input  logic                 reset,
  llander_thrust_ctrl_if.slave bus
);

  localparam logic [THRUST_W-1:0] MAX_T    = THRUST_W'(MAX_THRUST);
  localparam logic [OVL_W-1:0]    OVL_LOAD = OVL_W'(OVL_CYCLES);

  thr_mode_t           state, state_next;
  logic                enter_dpad;
  logic                tick;
  logic [7:0]          y_off;
  logic [8:0]          av_raw;
  logic [THRUST_W-1:0] av_c, av_q, dp, thrust_q;
  int                  x_s;
  logic                turn_l_q, turn_r_q;
  logic [OVL_W-1:0]    ovc, ovc_next;
  logic                ovl_en_q;

  // y + 128 is the offset-binary view of the signed stick value.
  always_comb begin
    y_off  = {~bus.analog_y[7], bus.analog_y[6:0]};
    av_raw = 9'd255 - {1'b0, y_off};
    av_c   = (av_raw > {1'b0, MAX_T}) ? MAX_T : av_raw[7:0];
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state <= ANALOG;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    enter_dpad = 1'b0;
    case (state)
      ANALOG: begin
        if (bus.dpad_mode) begin
          state_next = DPAD;
          enter_dpad = 1'b1;
        end
      end
      DPAD: begin
        if (!bus.dpad_mode) begin
          state_next = ANALOG;
        end
      end
      default: state_next = ANALOG;
    endcase
  end

  // Clearing on entry makes the first D-pad step a full period after handover.
  llander_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_50 (clk_50),
    .reset  (reset),
    .clr    (enter_dpad),
    .tick   (tick)
  );

  // Loading the current analog value on entry is what makes the switch bumpless.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      dp <= '0;
    end else if (enter_dpad) begin
      dp <= av_q;
    end else if (state == DPAD && tick) begin
      if (bus.thr_up && !bus.thr_down && dp < MAX_T) begin
        dp <= dp + THRUST_W'(1);
      end else if (bus.thr_down && !bus.thr_up && dp != '0) begin
        dp <= dp - THRUST_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      av_q     <= '0;
      thrust_q <= '0;
    end else begin
      av_q     <= av_c;
      thrust_q <= (state == DPAD) ? dp : av_q;
    end
  end

  assign x_s = int'($signed(bus.analog_x));

  always_ff @(posedge clk_50) begin
    if (reset) begin
      turn_l_q <= 1'b0;
      turn_r_q <= 1'b0;
    end else begin
      if (x_s < -TURN_ON) begin
        turn_l_q <= 1'b1;
      end else if (x_s > -TURN_OFF) begin
        turn_l_q <= 1'b0;
      end
      if (x_s > TURN_ON) begin
        turn_r_q <= 1'b1;
      end else if (x_s < TURN_OFF) begin
        turn_r_q <= 1'b0;
      end
    end
  end

  // Holding select keeps reloading, so the window is measured from release.
  always_comb begin
    if (!bus.sel_n) begin
      ovc_next = OVL_LOAD;
    end else if (ovc != '0) begin
      ovc_next = ovc - OVL_W'(1);
    end else begin
      ovc_next = ovc;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      ovc      <= '0;
      ovl_en_q <= 1'b0;
    end else begin
      ovc      <= ovc_next;
      ovl_en_q <= (ovc_next != '0);
    end
  end

  assign bus.thrust = thrust_q;
  assign bus.turn_l = turn_l_q;
  assign bus.turn_r = turn_r_q;
  assign bus.ovl_en = ovl_en_q;

endmodule
